// File: rtl/fnd_scan_controller.sv
// Four-digit seven-segment scan controller: steps positions 3..0, one slot each, with dead time and registered outputs.
// Optional leading-zero blanking is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller #(
  parameter int P_TICK_DIV = 100000,
  parameter int P_DEAD     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_value,
  input  logic [3:0] i_dpEnable,
  input  logic       i_blank,
  output logic [1:0] o_digitPosition,
  output logic [3:0] o_fndDigit,
  output logic [7:0] o_fndFont
);

  localparam int CNT_W = $clog2(P_TICK_DIV);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(P_TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(P_DEAD);

  logic [CNT_W-1:0] slot_cnt;
  logic             terminal;
  logic             in_dead;
  logic             lz_blank;
  logic             digit_off;
  logic [3:0]       next_digit;
  logic [7:0]       next_font;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, for a full hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign terminal = (slot_cnt == TERM_CNT);
  assign in_dead  = (slot_cnt < DEAD_CNT);

  // Position steps downward once per slot; 2'b00 - 1 wraps naturally to 2'b11.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_cnt        <= '0;
      o_digitPosition <= 2'b11;
    end else if (terminal) begin
      slot_cnt        <= '0;
      o_digitPosition <= o_digitPosition - 2'd1;
    end else begin
      slot_cnt        <= slot_cnt + 1'b1;
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic nonzero_seen;

  // Remembers a nonzero digit to the left; cleared as each new frame starts at position 3.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nonzero_seen <= 1'b0;
    end else if (terminal) begin
      if (o_digitPosition == 2'd0)
        nonzero_seen <= 1'b0;
      else if (i_value != 4'h0)
        nonzero_seen <= 1'b1;
    end
  end

  assign lz_blank = (o_digitPosition != 2'd0) && !nonzero_seen && (i_value == 4'h0);
`else
  assign lz_blank = 1'b0;
`endif

  assign digit_off = in_dead | i_blank | lz_blank;

  always_comb begin
    next_digit = 4'hF;
    next_font  = 8'hFF;
    if (!digit_off) begin
      next_digit = ~(4'b0001 << o_digitPosition);
      next_font  = {~i_dpEnable[o_digitPosition], hex_to_seg(i_value)};
    end
  end

  // Registering the enables and segments together keeps only one digit lit per cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fndDigit <= 4'hF;
      o_fndFont  <= 8'hFF;
    end else begin
      o_fndDigit <= next_digit;
      o_fndFont  <= next_font;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller (P_TICK_DIV=8, P_DEAD=2); expectations follow FND_LEADING_ZERO_BLANK_EN when defined.
module tb_fnd_scan_controller;

  localparam int TICK = 8;
  localparam int DEAD = 2;

  typedef struct {
    logic [15:0] vals;
    logic [3:0]  dp;
    logic [3:0]  lit;
    logic [31:0] fonts;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_value;
  logic [3:0]  i_dpEnable = 4'h0;
  logic        i_blank = 1'b0;
  logic [1:0]  o_digitPosition;
  logic [3:0]  o_fndDigit;
  logic [7:0]  o_fndFont;

  logic [15:0] val_word = 16'h0000;
  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  int          cur_k = 0;

  fnd_scan_controller #(.P_TICK_DIV(TICK), .P_DEAD(DEAD)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_value(i_value),
    .i_dpEnable(i_dpEnable),
    .i_blank(i_blank),
    .o_digitPosition(o_digitPosition),
    .o_fndDigit(o_fndDigit),
    .o_fndFont(o_fndFont)
  );

  // Digit-value mux driven by the scan position, as on the board.
  assign i_value = val_word[{o_digitPosition, 2'b00} +: 4];

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got %h want %h", name, cur_k, act, exp);
    end
  endtask

  // Runs ncyc cycles of vector idx, checking every output after each edge.
  task automatic applyStimulus(input int idx, input int ncyc, input int blank_lo,
                               input int blank_hi, input bit do_reset);
    int slot, cnt, out_pos, exp_pos;
    bit off;
    logic [3:0] exp_digit;
    logic [7:0] exp_font;
    val_word   = vecs[idx].vals;
    i_dpEnable = vecs[idx].dp;
    i_blank    = 1'b0;
    if (do_reset) begin
      i_reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      cur_k = 0;
      checkOutput("reset_pos", {6'b0, o_digitPosition}, 8'h03);
      checkOutput("reset_digit", {4'b0, o_fndDigit}, 8'h0F);
      checkOutput("reset_font", o_fndFont, 8'hFF);
      i_reset = 1'b0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      cur_k   = k;
      i_blank = (k >= blank_lo) && (k <= blank_hi);
      @(posedge i_clk);
      #1;
      slot    = ((k - 1) / TICK) % 4;
      cnt     = (k - 1) % TICK;
      out_pos = 3 - slot;
      exp_pos = 3 - ((k / TICK) % 4);
      off     = (cnt < DEAD) || i_blank || !vecs[idx].lit[out_pos];
      exp_digit = off ? 4'hF : ~(4'b0001 << out_pos);
      exp_font  = off ? 8'hFF : vecs[idx].fonts[out_pos*8 +: 8];
      checkOutput("position", {6'b0, o_digitPosition}, 8'(exp_pos));
      checkOutput("digit", {4'b0, o_fndDigit}, {4'b0, exp_digit});
      checkOutput("font", o_fndFont, exp_font);
    end
    i_blank = 1'b0;
  endtask

  initial begin
    // fonts packed {pos3,pos2,pos1,pos0}
    vecs[0] = '{vals: 16'h1234, dp: 4'b0000, lit: 4'hF, fonts: 32'hF9A4B099};
    vecs[1] = '{vals: 16'h8888, dp: 4'b0100, lit: 4'hF, fonts: 32'h80008080};
`ifdef FND_LEADING_ZERO_BLANK_EN
    vecs[2] = '{vals: 16'h0040, dp: 4'b1001, lit: 4'b0011, fonts: 32'hFFFF9940};
    vecs[3] = '{vals: 16'h0000, dp: 4'b0000, lit: 4'b0001, fonts: 32'hFFFFFFC0};
`else
    vecs[2] = '{vals: 16'h0040, dp: 4'b1001, lit: 4'hF, fonts: 32'h40C09940};
    vecs[3] = '{vals: 16'h0000, dp: 4'b0000, lit: 4'hF, fonts: 32'hC0C0C0C0};
`endif
    vecs[4] = '{vals: 16'hABCD, dp: 4'b1111, lit: 4'hF, fonts: 32'h08034621};
    vecs[5] = '{vals: 16'hEF05, dp: 4'b0001, lit: 4'hF, fonts: 32'h868EC012};
    vecs[6] = '{vals: 16'h6790, dp: 4'b1000, lit: 4'hF, fonts: 32'h02F890C0};

    for (int v = 0; v < 7; v++) begin
      applyStimulus(v, 2 * 4 * TICK, 0, -1, 1'b1);
    end

    // Blank held for edges 12..14, inside the position-2 slot.
    applyStimulus(0, 4 * TICK, 12, 14, 1'b1);

    // Reset at position 1, counter 5, then resume from position 3 with dead time.
    applyStimulus(0, 21, 0, -1, 1'b1);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    cur_k = 22;
    checkOutput("midreset_pos", {6'b0, o_digitPosition}, 8'h03);
    checkOutput("midreset_digit", {4'b0, o_fndDigit}, 8'h0F);
    checkOutput("midreset_font", o_fndFont, 8'hFF);
    i_reset = 1'b0;
    applyStimulus(0, 4 * TICK, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter P_TICK_DIV, default 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter P_DEAD, default 4, cycles at slot start with all digits off (anti-ghosting); legal range 0 to P_TICK_DIV-1.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_value, input, 4, hex digit for the position currently on o_digitPosition (supplied combinationally by the digit-value mux).
REQ-006 SHALL have port i_dpEnable, input, 4, per-position decimal point request, active-high, bit n = position n.
REQ-007 SHALL have port i_blank, input, 1, forces all digits off while high.
REQ-008 SHALL have port o_digitPosition, output, 2, registered scan position driving the mux select (0 = ones, 3 = thousands).
REQ-009 SHALL have port o_fndDigit, output, 4, registered active-low one-hot digit enable, bit n = position n.
REQ-010 SHALL have port o_fndFont, output, 8, registered active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-011 Slot counter SHALL count 0..P_TICK_DIV-1 and wrap to 0; terminal count = P_TICK_DIV-1.
REQ-012 At terminal count o_digitPosition SHALL step 3->2->1->0->3 (descending, 0 wraps to 3); otherwise hold.
REQ-013 o_fndDigit/o_fndFont SHALL have one-cycle latency: values at edge t+1 derive from o_digitPosition, i_value, i_dpEnable, i_blank, counter sampled at edge t.
REQ-014 Font decode SHALL be full hex: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (dp bit = 1).
REQ-015 dp bit SHALL be 0 when i_dpEnable[o_digitPosition]=1, else 1.
REQ-016 o_fndDigit SHALL be 4'hF when counter < P_DEAD or i_blank=1; otherwise ~(1 << o_digitPosition).
REQ-017 o_fndFont SHALL be 8'hFF whenever o_fndDigit is 4'hF.
REQ-018 i_blank SHALL act on the next edge and SHALL NOT stop the counter or the position stepping.
REQ-019 P_DEAD=0 SHALL yield no dead time; outputs never glitch between two enabled digits within one cycle.

Reset
REQ-020 While i_reset=1 at an edge: counter=0, o_digitPosition=2'b11, o_fndDigit=4'hF, o_fndFont=8'hFF, leading-zero flag cleared.
REQ-021 Reset asserted mid-slot or mid-frame SHALL abort the frame; first slot after release is position 3 with full P_DEAD dead time.

Configuration
REQ-022 Macro FND_LEADING_ZERO_BLANK_EN SHALL, when defined, enable leading-zero blanking; when undefined, every digit is always displayed and no flag register exists.
REQ-023 With macro: a nonzero flag SHALL clear on entering position 3 and set at a slot's terminal count if i_value != 0.
REQ-024 With macro: positions 3..1 SHALL be blanked (digit off, font FF, dp suppressed) when flag=0 and i_value=0; position 0 is never blanked (value 0000 shows "0").

Verification (P_TICK_DIV=8, P_DEAD=2 unless stated)
REQ-025 Reset release, values 1,2,3,4 (pos 3..0) -> position 3,2,1,0 every 8 cycles; digits F7,FB,FD,FE each for 6 cycles after 2 cycles F; fonts F9,A4,B0,99.
REQ-026 i_dpEnable=4'b0100, value 8 everywhere -> font 00 only in position-2 slot, 80 elsewhere.
REQ-027 Macro defined, values 0,0,4,0 (pos 3..0) -> positions 3,2 digit F/font FF; position 1 shows 99; position 0 shows C0.
REQ-028 Macro defined, all zeros -> only position 0 lit with C0; macro undefined -> all four show C0.
REQ-029 i_blank pulsed 3 cycles mid-slot -> o_fndDigit=F for exactly those 3 cycles delayed by 1; position timing unchanged.
REQ-030 i_reset asserted while at position 1, counter 5 -> next edge outputs F/FF, position 3; resumes per REQ-021.
